// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - forwarding, stall and mult/div busy tracking for the five-stage MIPS pipeline
// Optional stall-cycle counter built only when HAZARD_PERF_EN is defined.
module pipe_hazard_unit #(
    parameter int REGW  = 5,
    parameter int MDLAT = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [REGW-1:0] RsD,
    input  logic [REGW-1:0] RtD,
    input  logic [REGW-1:0] RsE,
    input  logic [REGW-1:0] RtE,
    input  logic            BranchD,
    input  logic            MdUseD,
    input  logic [REGW-1:0] WriteRegE,
    input  logic [REGW-1:0] WriteRegM,
    input  logic [REGW-1:0] WriteRegW,
    input  logic            RegWriteE,
    input  logic            RegWriteM,
    input  logic            RegWriteW,
    input  logic            MemtoRegE,
    input  logic            MemtoRegM,
    input  logic            MdStartE,
    output logic            StallF,
    output logic            StallD,
    output logic            FlushE,
    output logic            ForwardAD,
    output logic            ForwardBD,
    output logic [1:0]      ForwardAE,
    output logic [1:0]      ForwardBE,
    output logic            MdBusy,
    output logic            MdDone,
    output logic [31:0]     StallCount
);

    localparam int CW = $clog2(MDLAT + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MDLAT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

    md_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic rsd_nz, rtd_nz, rse_nz, rte_nz;
    logic lwstall, branchstall, mdstall, stall;

    assign rsd_nz = (RsD != '0);
    assign rtd_nz = (RtD != '0);
    assign rse_nz = (RsE != '0);
    assign rte_nz = (RtE != '0);

    always_comb begin
        ForwardAE = 2'b00;
        if (rse_nz && RegWriteM && (WriteRegM == RsE))
            ForwardAE = 2'b10;
        else if (rse_nz && RegWriteW && (WriteRegW == RsE))
            ForwardAE = 2'b01;

        ForwardBE = 2'b00;
        if (rte_nz && RegWriteM && (WriteRegM == RtE))
            ForwardBE = 2'b10;
        else if (rte_nz && RegWriteW && (WriteRegW == RtE))
            ForwardBE = 2'b01;
    end

    assign ForwardAD = rsd_nz && RegWriteM && (WriteRegM == RsD);
    assign ForwardBD = rtd_nz && RegWriteM && (WriteRegM == RtD);

    assign lwstall = MemtoRegE &&
                     ((rsd_nz && (RtE == RsD)) || (rtd_nz && (RtE == RtD)));

    // A branch compares in D, so an ALU result still in E, or load data still in M, cannot reach it.
    assign branchstall = BranchD &&
        ((RegWriteE && ((rsd_nz && (WriteRegE == RsD)) || (rtd_nz && (WriteRegE == RtD)))) ||
         (MemtoRegM && ((rsd_nz && (WriteRegM == RsD)) || (rtd_nz && (WriteRegM == RtD)))));

    assign mdstall = MdUseD && (busy_q || MdStartE);

    assign stall  = lwstall || branchstall || mdstall;
    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall;

    // A start arriving while busy is dropped; the D-stage stall keeps that from happening in practice.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (MdStartE) begin
                    state_d = MD_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            MD_BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE)
                    state_d = MD_IDLE;
            end
        endcase
        busy_d = (cnt_d != '0);
        done_d = (cnt_d == CNT_ONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign MdBusy = busy_q;
    assign MdDone = done_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_count_q, stall_count_d;

    always_comb stall_count_d = stall_count_q + {31'd0, stall};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_count_q <= '0;
        else
            stall_count_q <= stall_count_d;
    end

    assign StallCount = stall_count_q;
`else
    assign StallCount = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb/tb_pipe_hazard_unit.sv - directed and randomized checks of pipe_hazard_unit against a cycle-indexed model
module tb_pipe_hazard_unit;
    localparam int REGW  = 5;
    localparam int MDLAT = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [REGW-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic            BranchD, MdUseD, RegWriteE, RegWriteM, RegWriteW;
    logic            MemtoRegE, MemtoRegM, MdStartE;
    logic            StallF, StallD, FlushE, ForwardAD, ForwardBD, MdBusy, MdDone;
    logic [1:0]      ForwardAE, ForwardBE;
    logic [31:0]     StallCount;

    pipe_hazard_unit #(.REGW(REGW), .MDLAT(MDLAT)) dut (
        .clk(clk), .reset(reset),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .BranchD(BranchD), .MdUseD(MdUseD),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .MdStartE(MdStartE),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MdBusy(MdBusy), .MdDone(MdDone), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    longint      t = 0;
    longint      md_last = -1;
    logic [31:0] perf = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_busy();
        return !reset && (t <= md_last);
    endfunction

    function automatic logic [1:0] m_fwd_e(input logic [REGW-1:0] src);
        if (src != 0 && RegWriteM && WriteRegM == src) return 2'b10;
        if (src != 0 && RegWriteW && WriteRegW == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic m_stall();
        logic [REGW-1:0] srcs [2];
        logic s;
        srcs[0] = RsD;
        srcs[1] = RtD;
        s = MdUseD && (m_busy() || MdStartE);
        foreach (srcs[i]) begin
            if (srcs[i] != 0) begin
                if (MemtoRegE && RtE == srcs[i]) s = 1'b1;
                if (BranchD && RegWriteE && WriteRegE == srcs[i]) s = 1'b1;
                if (BranchD && MemtoRegM && WriteRegM == srcs[i]) s = 1'b1;
            end
        end
        return s;
    endfunction

    function automatic logic [31:0] m_count();
`ifdef HAZARD_PERF_EN
        return perf;
`else
        return 32'd0;
`endif
    endfunction

    task automatic check_model();
        logic s;
        s = m_stall();
        chk("m_stallf", {31'd0, StallF}, {31'd0, s});
        chk("m_stalld", {31'd0, StallD}, {31'd0, s});
        chk("m_flushe", {31'd0, FlushE}, {31'd0, s});
        chk("m_fwdae", {30'd0, ForwardAE}, {30'd0, m_fwd_e(RsE)});
        chk("m_fwdbe", {30'd0, ForwardBE}, {30'd0, m_fwd_e(RtE)});
        chk("m_fwdad", {31'd0, ForwardAD}, {31'd0, RsD != 0 && RegWriteM && WriteRegM == RsD});
        chk("m_fwdbd", {31'd0, ForwardBD}, {31'd0, RtD != 0 && RegWriteM && WriteRegM == RtD});
        chk("m_busy", {31'd0, MdBusy}, {31'd0, m_busy()});
        chk("m_done", {31'd0, MdDone}, {31'd0, m_busy() && t == md_last});
        chk("m_count", StallCount, m_count());
    endtask

    // One clock edge: the model absorbs the pre-edge inputs, then inputs may change 1 time unit later.
    task automatic advance();
        logic s;
        @(posedge clk);
        s = m_stall();
        if (reset) begin
            md_last = -1;
            perf    = 0;
        end else begin
            if (MdStartE && !(t <= md_last)) md_last = t + MDLAT;
            if (s) perf++;
        end
        t++;
        #1;
    endtask

    task automatic clear_inputs();
        {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
        {BranchD, MdUseD, RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MdStartE} = '0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        #2;
        chk("rst_busy", {31'd0, MdBusy}, 32'd0);
        chk("rst_done", {31'd0, MdDone}, 32'd0);
        chk("rst_count", StallCount, 32'd0);
        chk("rst_stall", {31'd0, StallD}, 32'd0);
        advance();
        advance();
        reset = 1'b0;
        check_model();

        // E forwarding priority
        RsE = 3; RegWriteM = 1; WriteRegM = 3; RegWriteW = 1; WriteRegW = 3; #2;
        chk("fwd_m_prio", {30'd0, ForwardAE}, 32'd2);
        check_model();
        RegWriteM = 0; #2;
        chk("fwd_w", {30'd0, ForwardAE}, 32'd1);
        RsE = 0; #2;
        chk("fwd_zero", {30'd0, ForwardAE}, 32'd0);
        advance();
        clear_inputs();

        // Load-use
        MemtoRegE = 1; RtE = 8; RsD = 8; #2;
        chk("lw_stallf", {31'd0, StallF}, 32'd1);
        chk("lw_stalld", {31'd0, StallD}, 32'd1);
        chk("lw_flushe", {31'd0, FlushE}, 32'd1);
        check_model();
        RsD = 9; #2;
        chk("lw_clear", {29'd0, StallF, StallD, FlushE}, 32'd0);
        advance();
        clear_inputs();

        // Branch hazard, then forward once the producer is in M
        BranchD = 1; RegWriteE = 1; WriteRegE = 4; RtD = 4; #2;
        chk("br_stall", {31'd0, StallD}, 32'd1);
        check_model();
        advance();
        RegWriteE = 0; WriteRegE = 0; RegWriteM = 1; WriteRegM = 4; MemtoRegM = 0; #2;
        chk("br_nostall", {31'd0, StallD}, 32'd0);
        chk("br_fwdbd", {31'd0, ForwardBD}, 32'd1);
        check_model();
        advance();
        clear_inputs();

        // Mult/div sequence, cycle 0 is the cycle MdStartE is high
        MdUseD = 1; MdStartE = 1; #2;
        chk("md_c0_stall", {31'd0, StallD}, 32'd1);
        chk("md_c0_busy", {31'd0, MdBusy}, 32'd0);
        advance();
        MdStartE = 0;
        for (int c = 1; c <= 5; c++) begin
            #2;
            chk($sformatf("md_c%0d_busy", c), {31'd0, MdBusy}, {31'd0, c <= 4});
            chk($sformatf("md_c%0d_done", c), {31'd0, MdDone}, {31'd0, c == 4});
            chk($sformatf("md_c%0d_stall", c), {31'd0, StallD}, {31'd0, c <= 4});
            check_model();
            advance();
        end

        // Reset while cnt==2
        MdStartE = 1; #2;
        advance();
        MdStartE = 0;
        advance();
        advance();
        reset = 1'b1; #1;
        md_last = -1;
        perf = 0;
        chk("rst_mid_busy", {31'd0, MdBusy}, 32'd0);
        chk("rst_mid_stall", {31'd0, StallD}, 32'd0);
        chk("rst_mid_count", StallCount, 32'd0);
        advance();
        reset = 1'b0;
        clear_inputs();

        // Seven stall cycles feed the perf counter
        MemtoRegE = 1; RtE = 5; RtD = 5;
        for (int c = 0; c < 7; c++) advance();
        clear_inputs(); #2;
        chk("perf_seven", StallCount, m_count());
`ifdef HAZARD_PERF_EN
        chk("perf_seven_abs", StallCount, 32'd7);
        @(negedge clk);
        force dut.stall_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_count_q;
        perf = 32'hFFFF_FFFF;
        MemtoRegE = 1; RtE = 5; RtD = 5;
        advance();
        clear_inputs(); #2;
        chk("perf_wrap", StallCount, 32'd0);
`else
        chk("perf_tied", StallCount, 32'd0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            RsD = REGW'($urandom_range(0, 3));
            RtD = REGW'($urandom_range(0, 3));
            RsE = REGW'($urandom_range(0, 3));
            RtE = REGW'($urandom_range(0, 3));
            WriteRegE = REGW'($urandom_range(0, 3));
            WriteRegM = REGW'($urandom_range(0, 3));
            WriteRegW = REGW'($urandom_range(0, 3));
            BranchD   = 1'($urandom_range(0, 1));
            MdUseD    = 1'($urandom_range(0, 1));
            RegWriteE = 1'($urandom_range(0, 1));
            RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1));
            MemtoRegE = ($urandom_range(0, 3) == 0);
            MemtoRegM = ($urandom_range(0, 3) == 0);
            MdStartE  = ($urandom_range(0, 5) == 0);
            #2;
            check_model();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
